// File: rtl/adc_seq_ctrl_if.sv
// rtl/adc_seq_ctrl_if.sv - trigger, ADC pin and result bundle for the ADC sequencer
interface adc_seq_ctrl_if #(
  parameter int ADC_N = 2,
  parameter int ADC_W = 12
);
  logic                   trig;
  logic                   ovr_clr;
  logic                   adc_cs_n;
  logic                   adc_sclk;
  logic                   adc_din;
  logic                   adc_dout;
  logic [ADC_N*ADC_W-1:0] adc_data;
  logic                   adc_val;
  logic                   busy;
  logic                   ovr;

  // master: PWM timer / consumer side plus the ADC's DOUT pin
  modport master (
    output trig, ovr_clr, adc_dout,
    input  adc_cs_n, adc_sclk, adc_din, adc_data, adc_val, busy, ovr
  );

  // slave: the sequencer itself
  modport slave (
    input  trig, ovr_clr, adc_dout,
    output adc_cs_n, adc_sclk, adc_din, adc_data, adc_val, busy, ovr
  );
endinterface

// File: rtl/adc_seq_ctrl.sv
// rtl/adc_seq_ctrl.sv - triggered burst sequencer for an 8-channel 12-bit SPI ADC
module adc_seq_ctrl #(
  parameter int                 ADC_N   = 2,
  parameter int                 ADC_W   = 12,
  parameter int                 CLK_DIV = 8,
  parameter logic [3*ADC_N-1:0] CH_MAP  = 6'b001_000
) (
  input logic           clk,
  input logic           rst,
  adc_seq_ctrl_if.slave bus
);

  localparam int             CW         = $clog2(CLK_DIV);
  localparam logic [CW-1:0]  DIV_LAST   = CW'(CLK_DIV - 1);
  localparam logic [3:0]     LAST_FRAME = 4'(ADC_N);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

  state_t                 state;
  logic [CW-1:0]          div_cnt;
  logic                   phase_hi;
  logic [3:0]             bit_idx;
  logic [3:0]             frame;
  logic [ADC_W-1:0]       sr;
  logic [ADC_N*ADC_W-1:0] shadow;

  logic                   cs_n_q;
  logic                   sclk_q;
  logic                   din_q;
  logic [ADC_N*ADC_W-1:0] data_q;
  logic                   val_q;
  logic                   busy_q;
  logic                   ovr_q;

  // ADC input address sent during frame f; the extra trailing frame re-addresses slot 0
  function automatic logic [2:0] frame_addr(input logic [3:0] f);
    logic [2:0] a;
    a = CH_MAP[2:0];
    for (int k = 0; k < ADC_N; k++) begin
      if (f == 4'(k)) a = CH_MAP[3*k +: 3];
    end
    return a;
  endfunction

  // DIN level for bit b of frame f: ADD2..ADD0 on bits 2..4, zero elsewhere
  function automatic logic din_bit(input logic [3:0] f, input logic [3:0] b);
    logic [2:0] a;
    a = frame_addr(f);
    case (b)
      4'd2:    return a[2];
      4'd3:    return a[1];
      4'd4:    return a[0];
      default: return 1'b0;
    endcase
  endfunction

  // burst FSM: CS setup, ADC_N+1 pipelined frames, then a single publish cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      div_cnt  <= '0;
      phase_hi <= 1'b0;
      bit_idx  <= '0;
      frame    <= '0;
      sr       <= '0;
      shadow   <= '0;
      cs_n_q   <= 1'b1;
      sclk_q   <= 1'b1;
      din_q    <= 1'b0;
      data_q   <= '0;
      val_q    <= 1'b0;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      val_q <= 1'b0;
      // a dropped trigger overrides a simultaneous clear
      if (bus.ovr_clr) ovr_q <= 1'b0;
      if (bus.trig && state != IDLE) ovr_q <= 1'b1;

      case (state)
        IDLE: begin
          if (bus.trig) begin
            state   <= SETUP;
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            div_cnt <= '0;
          end
        end

        SETUP: begin
          if (div_cnt == DIV_LAST) begin
            state    <= SHIFT;
            div_cnt  <= '0;
            phase_hi <= 1'b0;
            bit_idx  <= '0;
            frame    <= '0;
            sclk_q   <= 1'b0;
            din_q    <= din_bit(4'd0, 4'd0);
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        SHIFT: begin
          if (div_cnt != DIV_LAST) begin
            div_cnt <= div_cnt + 1'b1;
          end else begin
            div_cnt <= '0;
            if (!phase_hi) begin
              // rising SCLK: ADC drove DOUT on the previous falling edge, so it is stable here
              phase_hi <= 1'b1;
              sclk_q   <= 1'b1;
              if (bit_idx >= 4'd4) sr <= {sr[ADC_W-2:0], bus.adc_dout};
            end else begin
              phase_hi <= 1'b0;
              if (bit_idx == 4'd15) begin
                // frame f carries the result addressed in frame f-1; frame 0 is discarded
                for (int k = 0; k < ADC_N; k++) begin
                  if (frame == 4'(k + 1)) shadow[k*ADC_W +: ADC_W] <= sr;
                end
                if (frame == LAST_FRAME) begin
                  state  <= DONE;
                  cs_n_q <= 1'b1;
                  sclk_q <= 1'b1;
                  din_q  <= 1'b0;
                  val_q  <= 1'b1;
                  for (int k = 0; k < ADC_N; k++) begin
                    data_q[k*ADC_W +: ADC_W] <= (frame == 4'(k + 1)) ? sr : shadow[k*ADC_W +: ADC_W];
                  end
                end else begin
                  frame   <= frame + 4'd1;
                  bit_idx <= '0;
                  sclk_q  <= 1'b0;
                  din_q   <= din_bit(frame + 4'd1, 4'd0);
                end
              end else begin
                bit_idx <= bit_idx + 4'd1;
                sclk_q  <= 1'b0;
                din_q   <= din_bit(frame, bit_idx + 4'd1);
              end
            end
          end
        end

        DONE: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.adc_cs_n = cs_n_q;
  assign bus.adc_sclk = sclk_q;
  assign bus.adc_din  = din_q;
  assign bus.adc_data = data_q;
  assign bus.adc_val  = val_q;
  assign bus.busy     = busy_q;
  assign bus.ovr      = ovr_q;

endmodule

// File: tb/tb_adc_seq_ctrl.sv
// tb/tb_adc_seq_ctrl.sv - scoreboard bench for adc_seq_ctrl with a behavioural ADC128S022 model
module tb_adc_seq_ctrl;

  localparam int ADC_N   = 2;
  localparam int ADC_W   = 12;
  localparam int CLK_DIV = 8;
  localparam int CS_LOW  = CLK_DIV + (ADC_N + 1) * 32 * CLK_DIV;
  localparam int FALLS   = 16 * (ADC_N + 1);

  typedef struct {
    int          vt;
    logic [23:0] d;
    logic [8:0]  a;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic trig = 1'b0;
  logic ovr_clr = 1'b0;
  int   cyc = 0;

  int checks = 0;
  int errors = 0;
  bit exp_ovr = 1'b0;

  logic [11:0] vals [8];
  exp_t        exp_q [2][$];

  logic        cs_n [2];
  logic        sclk [2];
  logic        din  [2];
  logic [23:0] data [2];
  logic        val  [2];
  logic        busy [2];
  logic        ovr  [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int g, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s inst%0d cycle %0d actual=%0h required=%0h", name, g, cyc, act, req);
    end
  endfunction

  function automatic logic [5:0] map_of(input int g);
    return (g == 0) ? 6'b001_000 : 6'b110_011;
  endfunction

  // expected result of a burst triggered at edge t: published CS_LOW cycles after the trigger edge
  function automatic exp_t make_exp(input int g, input int t);
    exp_t       e;
    logic [5:0] m;
    logic [2:0] ch;
    m    = map_of(g);
    e.vt = t + CS_LOW;
    e.d  = '0;
    for (int k = 0; k < ADC_N; k++) begin
      ch = m[3*k +: 3];
      e.d[12*k +: 12] = vals[ch];
    end
    e.a = {m[2:0], m[5:3], m[2:0]};
    return e;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam logic [5:0] MAP = (g == 0) ? 6'b001_000 : 6'b110_011;

    logic dout = 1'b0;

    adc_seq_ctrl_if #(.ADC_N(ADC_N), .ADC_W(ADC_W)) bus ();

    assign bus.trig     = trig;
    assign bus.ovr_clr  = ovr_clr;
    assign bus.adc_dout = dout;
    assign cs_n[g]      = bus.adc_cs_n;
    assign sclk[g]      = bus.adc_sclk;
    assign din[g]       = bus.adc_din;
    assign data[g]      = bus.adc_data;
    assign val[g]       = bus.adc_val;
    assign busy[g]      = bus.busy;
    assign ovr[g]       = bus.ovr;

    adc_seq_ctrl #(.ADC_N(ADC_N), .ADC_W(ADC_W), .CLK_DIV(CLK_DIV), .CH_MAP(MAP)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    int         b = -1;
    int         falls = 0;
    int         cslow = 0;
    int         run = 0;
    int         bad_phase = 0;
    int         bad_idle = 0;
    logic [2:0] cur = 3'd0;
    logic [2:0] nxt = 3'd0;
    logic       pcs = 1'b1;
    logic       psclk = 1'b1;
    logic       pval = 1'b0;
    logic [2:0] alog [$];
    exp_t       e;
    logic [8:0] got;

    // ADC model plus SCLK/CS measurement, then the scoreboard monitor
    always @(negedge clk) begin
      if (!cs_n[g] && pcs) begin
        b = -1; cur = 3'd0; falls = 0; cslow = 0; run = 0; bad_phase = 0;
        alog.delete();
      end
      if (cs_n[g]) begin
        if (!sclk[g]) bad_idle++;
        dout = 1'b0;
      end else begin
        cslow++;
        if (!pcs && sclk[g] != psclk) begin
          if (run != CLK_DIV) bad_phase++;
          run = 0;
        end
        run++;
        if (!pcs && psclk && !sclk[g]) begin
          falls++;
          if (b == 15) begin
            cur = nxt;
            b = 0;
          end else begin
            b++;
          end
          dout = (b >= 4) ? vals[cur][15-b] : 1'b0;
        end
        if (!pcs && !psclk && sclk[g] && b >= 2 && b <= 4) begin
          nxt[4-b] = din[g];
          if (b == 4) alog.push_back(nxt);
        end
      end

      if (val[g]) begin
        chk("val_single_cycle", g, pval, 1'b0);
        if (exp_q[g].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_val inst%0d cycle %0d actual=1 required=0", g, cyc);
        end else begin
          e = exp_q[g].pop_front();
          got = '0;
          for (int i = 0; i < alog.size() && i < 3; i++) got[8-3*i -: 3] = alog[i];
          chk("val_time", g, cyc, e.vt);
          chk("data", g, data[g], e.d);
          chk("addr_count", g, alog.size(), 3);
          chk("addr_seq", g, got, e.a);
          chk("sclk_falls", g, falls, FALLS);
          chk("cs_low_cycles", g, cslow, CS_LOW);
          chk("sclk_phase_len", g, bad_phase, 0);
          chk("sclk_high_idle", g, bad_idle, 0);
        end
      end
      pval  = val[g];
      pcs   = cs_n[g];
      psclk = sclk[g];
    end
  end

  task automatic clear_ovr();
    @(negedge clk);
    ovr_clr = 1'b1;
    @(negedge clk);
    ovr_clr = 1'b0;
    exp_ovr = 1'b0;
    for (int g = 0; g < 2; g++) chk("ovr_cleared", g, ovr[g], 1'b0);
  endtask

  // one burst; viol_off>0 adds a dropped trig sampled at edge T+viol_off, rst_off>0 resets at T+rst_off
  task automatic run_burst(input int gap, input bit rnd, input int viol_off, input bit viol_clr, input int rst_off);
    int t;
    int rel;
    repeat (gap) @(negedge clk);
    if (rnd) for (int c = 0; c < 8; c++) vals[c] = 12'($urandom);
    for (int g = 0; g < 2; g++) chk("idle_busy", g, busy[g], 1'b0);
    trig = 1'b1;
    t = cyc + 1;
    for (int g = 0; g < 2; g++) exp_q[g].push_back(make_exp(g, t));
    rel = -1;
    while (rel < CS_LOW + 1) begin
      @(negedge clk);
      rel = cyc - t;
      trig = 1'b0;
      ovr_clr = 1'b0;
      rst = 1'b0;
      if (rel == 0) begin
        for (int g = 0; g < 2; g++) begin
          chk("start_cs_n", g, cs_n[g], 1'b0);
          chk("start_busy", g, busy[g], 1'b1);
          chk("setup_sclk", g, sclk[g], 1'b1);
        end
      end
      if (rst_off > 0 && rel == rst_off) begin
        for (int g = 0; g < 2; g++) begin
          chk("rst_cs_n", g, cs_n[g], 1'b1);
          chk("rst_sclk", g, sclk[g], 1'b1);
          chk("rst_din", g, din[g], 1'b0);
          chk("rst_busy", g, busy[g], 1'b0);
          chk("rst_data", g, data[g], 24'h0);
          chk("rst_ovr", g, ovr[g], 1'b0);
          if (exp_q[g].size() > 0) void'(exp_q[g].pop_back());
        end
        exp_ovr = 1'b0;
        break;
      end
      if (viol_off > 0 && rel == viol_off - 1) begin
        trig = 1'b1;
        ovr_clr = viol_clr;
        exp_ovr = 1'b1;
      end
      if (rst_off > 0 && rel == rst_off - 1) rst = 1'b1;
      if (rel == CS_LOW + 1) begin
        for (int g = 0; g < 2; g++) begin
          chk("end_busy", g, busy[g], 1'b0);
          chk("end_ovr", g, ovr[g], exp_ovr);
        end
      end
    end
  endtask

  initial begin
    for (int c = 0; c < 8; c++) vals[c] = 12'(c * 12'h111);
    vals[0] = 12'hA5C;
    vals[1] = 12'h3F1;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("reset_cs_n", g, cs_n[g], 1'b1);
      chk("reset_sclk", g, sclk[g], 1'b1);
      chk("reset_din", g, din[g], 1'b0);
      chk("reset_data", g, data[g], 24'h0);
      chk("reset_val", g, val[g], 1'b0);
      chk("reset_busy", g, busy[g], 1'b0);
      chk("reset_ovr", g, ovr[g], 1'b0);
    end
    rst = 1'b0;

    run_burst(2, 1'b0, 0, 1'b0, 0);
    run_burst(5, 1'b0, 100, 1'b0, 0);
    run_burst(0, 1'b1, 300, 1'b1, 0);
    clear_ovr();
    run_burst(3, 1'b1, CS_LOW + 1, 1'b0, 0);
    clear_ovr();
    run_burst(4, 1'b1, 0, 1'b0, 400);
    repeat (CS_LOW + 100) @(negedge clk);
    run_burst(1, 1'b1, 0, 1'b0, 0);
    run_burst(0, 1'b1, 0, 1'b0, 0);

    for (int i = 0; i < 8; i++) begin
      int  v;
      bit  c;
      v = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, CS_LOW + 1)) : 0;
      c = 1'($urandom_range(0, 1));
      run_burst(int'($urandom_range(0, 20)), 1'b1, v, c, 0);
      if (exp_ovr && $urandom_range(0, 1) == 1) clear_ovr();
    end

    repeat (5) @(negedge clk);
    for (int g = 0; g < 2; g++) chk("pending_val", g, exp_q[g].size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog cycle %0d actual=running required=finished", cyc);
    $fatal(1);
  end

endmodule
